// File: rtl/mor1kx_rf_pkg.sv
// Shared types and constants for the cappuccino GPR-file write scheduler.
package mor1kx_rf_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WR_WAIT,
    RD_DATA,
    ACK
  } rf_sched_state_e;

  // GPR window on the SPR bus: 0x400-0x7FF (group 0, bit 10 set).
  localparam logic [15:0] GPR_SPR_BASE = 16'h0400;
  localparam logic [15:0] GPR_SPR_MASK = 16'hFC00;

  // Width of the set field in an RF address; at least one bit even with no shadow sets.
  function automatic int rf_set_w(input int num_shadow);
    int w;
    w = $clog2(1 + num_shadow);
    if (w < 1) w = 1;
    return w;
  endfunction

  // Full RF address width: {set, index}.
  function automatic int rf_full_aw(input int aw, input int num_shadow);
    return aw + rf_set_w(num_shadow);
  endfunction

endpackage

// File: rtl/mor1kx_rf_clear_seq.sv
// Post-reset clear address generator: walks 0..LAST while enabled and flags the last word.
module mor1kx_rf_clear_seq #(
  parameter int AW   = 6,
  parameter int LAST = 31
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] clr_cnt,
  output logic          clr_done
);

  localparam logic [AW-1:0] LAST_ADR = AW'(LAST);

  assign clr_done = en && (clr_cnt == LAST_ADR);

  // Address counter; wraps to zero once the last word has been written.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (en) begin
      clr_cnt <= clr_done ? '0 : clr_cnt + AW'(1);
    end
  end

endmodule

// File: rtl/mor1kx_rf_wrsched_cappuccino.sv
// Cappuccino GPR-file port scheduler: post-reset clear, writeback vs SPR-bus write
// arbitration on the single write port, and SPR-bus reads through the aux read port.
// Build option: MOR1KX_RF_CLEAR_ON_INIT_EN enables the clear sequence after reset.
module mor1kx_rf_wrsched_cappuccino
  import mor1kx_rf_pkg::*;
#(
  parameter int OPTION_RF_ADDR_WIDTH     = 5,
  parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
  parameter int OPTION_OPERAND_WIDTH     = 32,
  parameter int STALL_THRESH             = 2
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          wb_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0]                               wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                               result_i,
  input  logic [15:0]                                                   spr_bus_addr_i,
  input  logic                                                          spr_bus_stb_i,
  input  logic                                                          spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                               spr_bus_dat_i,
  output logic                                                          spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]                               spr_gpr_dat_o,
  output logic                                                          rf_we_o,
  output logic [rf_full_aw(OPTION_RF_ADDR_WIDTH, OPTION_RF_NUM_SHADOW_GPR)-1:0] rf_wadr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0]                               rf_wdat_o,
  output logic                                                          rf_re_o,
  output logic [rf_full_aw(OPTION_RF_ADDR_WIDTH, OPTION_RF_NUM_SHADOW_GPR)-1:0] rf_radr_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0]                               rf_rdat_i,
  output logic                                                          init_busy_o,
  output logic                                                          pipe_stall_o
);

  localparam int AW        = OPTION_RF_ADDR_WIDTH;
  localparam int OW        = OPTION_OPERAND_WIDTH;
  localparam int FULL_AW   = rf_full_aw(AW, OPTION_RF_NUM_SHADOW_GPR);
  localparam int SET_W     = FULL_AW - AW;
  localparam int SPR_SET_W = 10 - AW;
  localparam int NUM_WORDS = (1 + OPTION_RF_NUM_SHADOW_GPR) << AW;
  localparam int WAIT_W    = $clog2(STALL_THRESH + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STALL_THRESH);

  rf_sched_state_e     state;
  rf_sched_state_e     state_d;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_cnt_d;
  logic                ack_d;
  logic                stall_d;
  logic [OW-1:0]       rd_dat_d;

  logic [FULL_AW-1:0]  clr_cnt;
  logic                clr_done;

  logic                spr_hit;
  logic                spr_set_ok;
  logic                spr_wr_issue;
  logic [SPR_SET_W-1:0] spr_set;
  logic [AW-1:0]       spr_idx;
  logic [FULL_AW-1:0]  spr_adr;

  // SPR address decode: GPR window, set/index split and set range check.
  assign spr_hit    = spr_bus_stb_i && ((spr_bus_addr_i & GPR_SPR_MASK) == GPR_SPR_BASE);
  assign spr_set    = spr_bus_addr_i[9:AW];
  assign spr_idx    = spr_bus_addr_i[AW-1:0];
  assign spr_adr    = {spr_set[SET_W-1:0], spr_idx};
  assign spr_set_ok = ({{(32-SPR_SET_W){1'b0}}, spr_set} <= 32'(OPTION_RF_NUM_SHADOW_GPR));

  // An SPR write goes to the RF only when writeback leaves the port free.
  assign spr_wr_issue = ((state == IDLE) || (state == WR_WAIT)) && spr_hit &&
                        spr_bus_we_i && spr_set_ok && !wb_rf_wb_i;

`ifdef MOR1KX_RF_CLEAR_ON_INIT_EN
  mor1kx_rf_clear_seq #(
    .AW   (FULL_AW),
    .LAST (NUM_WORDS - 1)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .en       (state == CLEAR),
    .clr_cnt  (clr_cnt),
    .clr_done (clr_done)
  );

  assign init_busy_o = (state == CLEAR);
`else
  assign clr_cnt     = '0;
  assign clr_done    = 1'b0;
  assign init_busy_o = 1'b0;
`endif

  // Write-port mux: clear beats writeback, writeback beats SPR writes.
  always_comb begin
    rf_we_o   = 1'b0;
    rf_wadr_o = '0;
    rf_wdat_o = '0;
    if (state == CLEAR) begin
      rf_we_o   = 1'b1;
      rf_wadr_o = clr_cnt;
    end else if (wb_rf_wb_i) begin
      rf_we_o   = 1'b1;
      rf_wadr_o = {{SET_W{1'b0}}, wb_rfd_adr_i};
      rf_wdat_o = result_i;
    end else if (spr_wr_issue) begin
      rf_we_o   = 1'b1;
      rf_wadr_o = spr_adr;
      rf_wdat_o = spr_bus_dat_i;
    end
  end

  // Aux read port: only in-range SPR reads touch the RF.
  assign rf_re_o   = (state == IDLE) && spr_hit && !spr_bus_we_i && spr_set_ok;
  assign rf_radr_o = spr_adr;

  // Next-state and next-register values for the scheduler.
  always_comb begin
    state_d    = state;
    wait_cnt_d = '0;
    rd_dat_d   = spr_gpr_dat_o;
    case (state)
      CLEAR: begin
`ifdef MOR1KX_RF_CLEAR_ON_INIT_EN
        if (clr_done) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      IDLE: begin
        if (spr_hit) begin
          if (spr_bus_we_i) begin
            // Out-of-range writes are dropped, so they never need the port.
            if (spr_set_ok && wb_rf_wb_i) state_d = WR_WAIT;
            else                          state_d = ACK;
          end else begin
            state_d = RD_DATA;
          end
        end
      end
      WR_WAIT: begin
        if (!wb_rf_wb_i) begin
          state_d = ACK;
        end else begin
          wait_cnt_d = (wait_cnt >= WAIT_MAX) ? wait_cnt : wait_cnt + WAIT_W'(1);
        end
      end
      RD_DATA: begin
        rd_dat_d = spr_set_ok ? rf_rdat_i : '0;
        state_d  = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ack_d = (state_d == ACK);

`ifdef MOR1KX_RF_CLEAR_ON_INIT_EN
  assign stall_d = (state_d == CLEAR) || ((state_d == WR_WAIT) && (wait_cnt_d >= WAIT_MAX));
`else
  assign stall_d = (state_d == WR_WAIT) && (wait_cnt_d >= WAIT_MAX);
`endif

  // State register and registered outputs; reset aborts any SPR access without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MOR1KX_RF_CLEAR_ON_INIT_EN
      state        <= CLEAR;
      pipe_stall_o <= 1'b1;
`else
      state        <= IDLE;
      pipe_stall_o <= 1'b0;
`endif
      wait_cnt      <= '0;
      spr_gpr_ack_o <= 1'b0;
      spr_gpr_dat_o <= '0;
    end else begin
      state         <= state_d;
      pipe_stall_o  <= stall_d;
      wait_cnt      <= wait_cnt_d;
      spr_gpr_ack_o <= ack_d;
      spr_gpr_dat_o <= rd_dat_d;
    end
  end

endmodule

// File: tb/tb_mor1kx_rf_wrsched_cappuccino.sv
// Self-checking bench for mor1kx_rf_wrsched_cappuccino (AW=5, one shadow set).
module tb_mor1kx_rf_wrsched_cappuccino;

  logic        clk;
  logic        rst;
  logic        wb_rf_wb_i;
  logic [4:0]  wb_rfd_adr_i;
  logic [31:0] result_i;
  logic [15:0] spr_bus_addr_i;
  logic        spr_bus_stb_i;
  logic        spr_bus_we_i;
  logic [31:0] spr_bus_dat_i;
  logic        spr_gpr_ack_o;
  logic [31:0] spr_gpr_dat_o;
  logic        rf_we_o;
  logic [5:0]  rf_wadr_o;
  logic [31:0] rf_wdat_o;
  logic        rf_re_o;
  logic [5:0]  rf_radr_o;
  logic [31:0] rf_rdat_i;
  logic        init_busy_o;
  logic        pipe_stall_o;

  mor1kx_rf_wrsched_cappuccino #(
    .OPTION_RF_ADDR_WIDTH     (5),
    .OPTION_RF_NUM_SHADOW_GPR (1),
    .OPTION_OPERAND_WIDTH     (32),
    .STALL_THRESH             (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_rf_wb_i     (wb_rf_wb_i),
    .wb_rfd_adr_i   (wb_rfd_adr_i),
    .result_i       (result_i),
    .spr_bus_addr_i (spr_bus_addr_i),
    .spr_bus_stb_i  (spr_bus_stb_i),
    .spr_bus_we_i   (spr_bus_we_i),
    .spr_bus_dat_i  (spr_bus_dat_i),
    .spr_gpr_ack_o  (spr_gpr_ack_o),
    .spr_gpr_dat_o  (spr_gpr_dat_o),
    .rf_we_o        (rf_we_o),
    .rf_wadr_o      (rf_wadr_o),
    .rf_wdat_o      (rf_wdat_o),
    .rf_re_o        (rf_re_o),
    .rf_radr_o      (rf_radr_o),
    .rf_rdat_i      (rf_rdat_i),
    .init_busy_o    (init_busy_o),
    .pipe_stall_o   (pipe_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_read;
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t sbq[$];

  typedef struct {
    logic        stb;
    logic        spr_we;
    logic [15:0] addr;
    logic [31:0] dat;
    logic        wb;
    logic [4:0]  wb_adr;
    logic [31:0] wb_dat;
    logic [31:0] rdat;
    logic        exp_we;
    logic [5:0]  exp_wadr;
    logic [31:0] exp_wdat;
    logic        exp_re;
    logic [5:0]  exp_radr;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (spr_gpr_ack_o === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("ack_cycle", cyc, e.due);
        if (e.is_read) chk("ack_rdata", spr_gpr_dat_o, e.dat);
      end
    end
  end

  // Checks the cycles right after reset release; called in the first cycle with rst low.
  task automatic clear_check(input string tag);
`ifdef MOR1KX_RF_CLEAR_ON_INIT_EN
    for (int i = 0; i < 64; i++) begin
      // Writeback during the clear must not disturb it.
      wb_rf_wb_i   = (i >= 10 && i < 13);
      wb_rfd_adr_i = 5'd9;
      result_i     = 32'hFFFF_FFFF;
      #1;
      chk($sformatf("%s_clr%0d_we", tag, i), rf_we_o, 32'd1);
      chk($sformatf("%s_clr%0d_wadr", tag, i), rf_wadr_o, i);
      chk($sformatf("%s_clr%0d_wdat", tag, i), rf_wdat_o, 32'd0);
      chk($sformatf("%s_clr%0d_busy", tag, i), init_busy_o, 32'd1);
      chk($sformatf("%s_clr%0d_stall", tag, i), pipe_stall_o, 32'd1);
      step();
    end
    wb_rf_wb_i = 1'b0;
`endif
    #1;
    chk({tag, "_done_busy"}, init_busy_o, 32'd0);
    chk({tag, "_done_stall"}, pipe_stall_o, 32'd0);
    chk({tag, "_done_we"}, rf_we_o, 32'd0);
  endtask

  // Applies one table vector starting in an idle cycle.
  task automatic run_vec(input int i);
    int c;
    bit found;
    step();
    c              = cyc;
    spr_bus_stb_i  = vt[i].stb;
    spr_bus_we_i   = vt[i].spr_we;
    spr_bus_addr_i = vt[i].addr;
    spr_bus_dat_i  = vt[i].dat;
    wb_rf_wb_i     = vt[i].wb;
    wb_rfd_adr_i   = vt[i].wb_adr;
    result_i       = vt[i].wb_dat;
    rf_rdat_i      = 32'hBAD0_BAD0;
    #1;
    chk($sformatf("v%0d_we", i), rf_we_o, vt[i].exp_we);
    if (vt[i].exp_we) begin
      chk($sformatf("v%0d_wadr", i), rf_wadr_o, vt[i].exp_wadr);
      chk($sformatf("v%0d_wdat", i), rf_wdat_o, vt[i].exp_wdat);
    end
    chk($sformatf("v%0d_re", i), rf_re_o, vt[i].exp_re);
    if (vt[i].exp_re) chk($sformatf("v%0d_radr", i), rf_radr_o, vt[i].exp_radr);
    if (vt[i].stb && vt[i].exp_ack) begin
      sbq.push_back('{is_read: !vt[i].spr_we, dat: vt[i].exp_rd, due: c + (vt[i].spr_we ? 1 : 2)});
      step();
      rf_rdat_i = vt[i].rdat;
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
        if (spr_gpr_ack_o === 1'b1) found = 1'b1;
        else step();
      end
      if (!found) chk($sformatf("v%0d_ack_timeout", i), 32'd0, 32'd1);
      spr_bus_stb_i = 1'b0;
    end else if (vt[i].stb) begin
      for (int k = 0; k < 4; k++) begin
        step();
        chk($sformatf("v%0d_nohit_we", i), rf_we_o, 32'd0);
        chk($sformatf("v%0d_nohit_re", i), rf_re_o, 32'd0);
      end
      spr_bus_stb_i = 1'b0;
    end
    wb_rf_wb_i = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000, expected 0x00000001");
    $fatal(1, "bench timed out");
  end

  initial begin
    int c;
    //           stb   we    addr      dat           wb    wbadr wbdat         rdat          | ewe  ewadr  ewdat         ere  eradr  eack erd
    vt[0]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 5'd7, 32'h1111_2222, 32'h0,         1'b1, 6'h07, 32'h1111_2222, 1'b0, 6'h00, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 16'h0000, 32'h0,        1'b1, 5'd0, 32'hFFFF_0000, 32'h0,         1'b1, 6'h00, 32'hFFFF_0000, 1'b0, 6'h00, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 1'b1, 16'h0405, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 6'h05, 32'hDEAD_BEEF, 1'b0, 6'h00, 1'b1, 32'h0};
    vt[3]  = '{1'b1, 1'b1, 16'h0425, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0,         32'h0,         1'b1, 6'h25, 32'hCAFE_F00D, 1'b0, 6'h00, 1'b1, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 16'h040A, 32'h0,        1'b0, 5'd0, 32'h0,         32'h0000_1234, 1'b0, 6'h00, 32'h0,         1'b1, 6'h0A, 1'b1, 32'h0000_1234};
    vt[5]  = '{1'b1, 1'b0, 16'h043F, 32'h0,        1'b0, 5'd0, 32'h0,         32'hA5A5_A5A5, 1'b0, 6'h00, 32'h0,         1'b1, 6'h3F, 1'b1, 32'hA5A5_A5A5};
    vt[6]  = '{1'b1, 1'b0, 16'h0445, 32'h0,        1'b0, 5'd0, 32'h0,         32'h7777_7777, 1'b0, 6'h00, 32'h0,         1'b0, 6'h00, 1'b1, 32'h0};
    vt[7]  = '{1'b1, 1'b1, 16'h0445, 32'h1234_5678, 1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 6'h00, 32'h0,         1'b0, 6'h00, 1'b1, 32'h0};
    vt[8]  = '{1'b1, 1'b0, 16'h0400, 32'h0,        1'b0, 5'd0, 32'h0,         32'hFFFF_FFFF, 1'b0, 6'h00, 32'h0,         1'b1, 6'h00, 1'b1, 32'hFFFF_FFFF};
    vt[9]  = '{1'b1, 1'b1, 16'h0011, 32'h1357_9BDF, 1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 6'h00, 32'h0,         1'b0, 6'h00, 1'b0, 32'h0};
    vt[10] = '{1'b1, 1'b0, 16'h0C05, 32'h0,        1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 6'h00, 32'h0,         1'b0, 6'h00, 1'b0, 32'h0};
    vt[11] = '{1'b1, 1'b1, 16'h0805, 32'h2468_ACE0, 1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 6'h00, 32'h0,         1'b0, 6'h00, 1'b0, 32'h0};

    rst            = 1'b1;
    wb_rf_wb_i     = 1'b0;
    wb_rfd_adr_i   = '0;
    result_i       = '0;
    spr_bus_addr_i = '0;
    spr_bus_stb_i  = 1'b0;
    spr_bus_we_i   = 1'b0;
    spr_bus_dat_i  = '0;
    rf_rdat_i      = '0;

    // Reset state.
    step();
    step();
    chk("rst_ack", spr_gpr_ack_o, 32'd0);
    chk("rst_dat", spr_gpr_dat_o, 32'd0);
`ifdef MOR1KX_RF_CLEAR_ON_INIT_EN
    chk("rst_stall", pipe_stall_o, 32'd1);
    chk("rst_busy", init_busy_o, 32'd1);
`else
    chk("rst_stall", pipe_stall_o, 32'd0);
    chk("rst_busy", init_busy_o, 32'd0);
`endif
    rst = 1'b0;
    clear_check("init");

    for (int i = 0; i < 12; i++) run_vec(i);

    // SPR write blocked by four cycles of writeback.
    step();
    c              = cyc;
    wb_rf_wb_i     = 1'b1;
    wb_rfd_adr_i   = 5'd3;
    result_i       = 32'h0BAD_F00D;
    spr_bus_stb_i  = 1'b1;
    spr_bus_we_i   = 1'b1;
    spr_bus_addr_i = 16'h0403;
    spr_bus_dat_i  = 32'h55AA_55AA;
    sbq.push_back('{is_read: 1'b0, dat: 32'h0, due: c + 5});
    #1;
    chk("ww_c0_wadr", rf_wadr_o, 32'd3);
    chk("ww_c0_wdat", rf_wdat_o, 32'h0BAD_F00D);
    chk("ww_c0_stall", pipe_stall_o, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("ww_c%0d_stall", k), pipe_stall_o, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("ww_c%0d_wdat", k), rf_wdat_o, 32'h0BAD_F00D);
    end
    step();
    wb_rf_wb_i = 1'b0;
    #1;
    chk("ww_issue_we", rf_we_o, 32'd1);
    chk("ww_issue_wadr", rf_wadr_o, 32'd3);
    chk("ww_issue_wdat", rf_wdat_o, 32'h55AA_55AA);
    chk("ww_issue_stall", pipe_stall_o, 32'd1);
    step();
    chk("ww_ack", spr_gpr_ack_o, 32'd1);
    chk("ww_ack_stall", pipe_stall_o, 32'd0);
    spr_bus_stb_i = 1'b0;
    step();

    // Reset while a read sits in RD_DATA: no ack, clear restarts from zero.
    step();
    spr_bus_stb_i  = 1'b1;
    spr_bus_we_i   = 1'b0;
    spr_bus_addr_i = 16'h040A;
    rf_rdat_i      = 32'h9999_9999;
    step();
    rst = 1'b1;
    step();
    chk("mid_rst_ack", spr_gpr_ack_o, 32'd0);
    chk("mid_rst_dat", spr_gpr_dat_o, 32'd0);
    spr_bus_stb_i = 1'b0;
    rst = 1'b0;
    clear_check("midrst");

    // Scheduler is usable again after the aborted access.
    run_vec(2);
    run_vec(4);

    repeat (3) step();
    chk("sb_drained", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mor1kx_rf_wrsched_cappuccino.md
Name: mor1kx_rf_wrsched_cappuccino

Overview:
Scheduler for the cappuccino GPR file's single write port and auxiliary read port. It sequences the post-reset register clear. It arbitrates the write port between pipeline writeback and SPR-bus (debug) GPR writes, and it services SPR-bus GPR reads. It sits between the pipeline writeback stage / SPR bus and the RF storage, and raises a pipeline stall when SPR traffic is starved or the clear is running.

Parameters:
OPTION_RF_ADDR_WIDTH, 5, index bits per GPR set
OPTION_RF_NUM_SHADOW_GPR, 0, number of shadow sets (total sets = 1 + this)
OPTION_OPERAND_WIDTH, 32, data width
STALL_THRESH, 2, cycles an SPR write may wait before pipe_stall_o asserts (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wb_rf_wb_i  in  1  writeback write request
wb_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  writeback GPR index (set 0)
result_i  in  OPTION_OPERAND_WIDTH  writeback data
spr_bus_addr_i  in  16  SPR address
spr_bus_stb_i  in  1  SPR strobe, held until ack
spr_bus_we_i  in  1  SPR write
spr_bus_dat_i  in  OPTION_OPERAND_WIDTH  SPR write data
spr_gpr_ack_o  out  1  registered one-cycle ack
spr_gpr_dat_o  out  OPTION_OPERAND_WIDTH  registered SPR read data
rf_we_o  out  1  RF write enable
rf_wadr_o  out  FULL_AW  RF write address {set, index}
rf_wdat_o  out  OPTION_OPERAND_WIDTH  RF write data
rf_re_o  out  1  aux read-port enable
rf_radr_o  out  FULL_AW  aux read address
rf_rdat_i  in  OPTION_OPERAND_WIDTH  aux read data, valid the cycle after rf_re_o
init_busy_o  out  1  clear sequence running
pipe_stall_o  out  1  pipeline stall request

Behaviour:
- FULL_AW = OPTION_RF_ADDR_WIDTH + max(1, $clog2(1+OPTION_RF_NUM_SHADOW_GPR)). Writeback always targets set 0.
- GPR SPR hit:
  - Hit when spr_bus_addr_i[15:11]==0 and spr_bus_addr_i[10]==1, i.e. 0x400–0x7FF.
  - index = addr[AW-1:0]; set = addr[9:AW].
  - Non-hits are ignored and never acked.
- Reset: state CLEAR (IDLE without macro); clr_cnt=0, wait_cnt=0; spr_gpr_ack_o=0, spr_gpr_dat_o=0, pipe_stall_o=1 (0 without macro). Mid-operation reset aborts any pending SPR access with no ack and restarts the clear.
- rf_we_o/rf_wadr_o/rf_wdat_o are combinational muxes. Priority: clear > writeback > SPR write.
- CLEAR:
  - Each cycle drives we=1, wadr=clr_cnt, wdat=0, then clr_cnt++.
  - After address (1+SHADOW)*2^AW-1, go to IDLE.
  - init_busy_o=1 and pipe_stall_o=1 throughout. wb_rf_wb_i and SPR stb are ignored (stb remains pending, serviced later).
- IDLE:
  - wb_rf_wb_i passes through the same cycle.
  - SPR write hit, no writeback: write issued this cycle, go to ACK.
  - SPR write hit with writeback active: go to WR_WAIT.
  - SPR read hit: rf_re_o=1, rf_radr_o={set,index}, go to RD_DATA.
- WR_WAIT:
  - Issue the write on the first cycle wb_rf_wb_i=0, then go to ACK.
  - wait_cnt counts cycles in WR_WAIT. When wait_cnt>=STALL_THRESH, pipe_stall_o=1 (registered) until the write issues.
- RD_DATA: capture rf_rdat_i into spr_gpr_dat_o, go to ACK.
- ACK: spr_gpr_ack_o=1 for exactly one cycle. stb is ignored this cycle; return to IDLE.
- Latency: SPR write ack 1 cycle after issue; SPR read ack 2 cycles after stb (IDLE→RD_DATA→ACK).
- Set > OPTION_RF_NUM_SHADOW_GPR:
  - Writes are dropped (no rf_we_o) but acked.
  - Reads return 0 and are acked; rf_re_o is not asserted.
- Writeback of index 0 is written as-is; r0 semantics are handled elsewhere.

Optional Feature:
MOR1KX_RF_CLEAR_ON_INIT_EN
- Defined: CLEAR state exists as above; clears all (1+SHADOW)*2^AW words after every reset.
- Undefined: reset enters IDLE directly; init_busy_o tied 0; pipe_stall_o driven only by WR_WAIT.

Decomposition:
- Shared package mor1kx_rf_pkg:
  - rf_sched_state_e enum {CLEAR, IDLE, WR_WAIT, RD_DATA, ACK}
  - GPR SPR base constant 16'h0400
  - function for FULL_AW
- One natural sub-module: mor1kx_rf_clear_seq (clr_cnt counter with done flag).

Test Plan:
- Reset with macro, AW=5, SHADOW=0 → rf_we_o high for 32 cycles, wadr 0..31, wdat 0; init_busy_o falls on cycle 32.
- IDLE, SPR write addr 0x405 data 0xDEADBEEF, no wb → rf_we_o same cycle, wadr=5, ack next cycle.
- SPR write 0x403 while wb_rf_wb_i high 4 cycles → pipe_stall_o rises after 2 wait cycles; write issued the cycle wb drops; ack next cycle.
- SPR read 0x40A with rf_rdat_i=0x1234 the following cycle → ack 2 cycles after stb, spr_gpr_dat_o=0x1234.
- SHADOW=1, read 0x445 → set 2 > 1, ack with 0, rf_re_o never asserted; write 0x425 → wadr={1,5}.
- rst asserted in RD_DATA → no ack; clear restarts at address 0.
